wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Writeback stage feeding the register file's single write port (we3/a3/wd3).
//   Arbitrates between the in-order execute result stream and out-of-order memory/long-latency responses.
//   Memory responses are buffered in a DEPTH-entry FIFO.
//   Exposes pending-write flags for hazard detection, and port_a_busy: a write steals rf read port A for that cycle.
// PARAMETERS
//   DATAW        32  write data width
//   ADDRW        6   register address width (addr 0 = hardwired zero)
//   DEPTH        4   memory-response FIFO entries (power of 2, >=2)
//   STARVE_LIMIT 8   cycles FIFO head may wait before execute stream is stalled
// PORTS
//   clk          in   1      clock
//   rst          in   1      synchronous reset, active-high
//   ex_valid     in   1      execute result valid
//   ex_ready     out  1      execute result accepted this cycle
//   ex_rd        in   ADDRW  execute destination register
//   ex_data      in   DATAW  execute result
//   mem_valid    in   1      memory response valid
//   mem_ready    out  1      FIFO can accept a response
//   mem_rd       in   ADDRW  memory destination register
//   mem_data     in   DATAW  memory response data
//   we3          out  1      rf write enable
//   a3           out  ADDRW  rf write address
//   wd3          out  DATAW  rf write data
//   port_a_busy  out  1      equals we3; decode must not rely on a1 read this cycle
//   q1, q2       in   ADDRW  hazard query addresses
//   q1_pend      out  1      q1 has a buffered, unwritten FIFO write
//   q2_pend      out  1      q2 has a buffered, unwritten FIFO write
// BEHAVIOUR
// - Reset (rst=1, sync):
//   - FIFO emptied; age counter = 0.
//   - Outputs forced: ex_ready=0, mem_ready=0, we3=0, q*_pend=0.
//   - a3/wd3 driven 0.
// - mem_ready = ~full, from registered count only.
//   - No same-cycle pop credit: when full, mem_ready=0 even if a pop occurs this cycle.
// - Push: mem_valid & mem_ready writes the tail entry.
//   - Data is visible at the head no earlier than the next cycle; there is no bypass.
// - Age counter:
//   - Increments each cycle the FIFO is non-empty and the head is not popped.
//   - Clears when the head is popped or the FIFO is empty; saturates at STARVE_LIMIT.
// - starve = (age >= STARVE_LIMIT).
// - Grant, combinational, in the same cycle:
//   - starve=1: ex_ready=0; the head is popped and written.
//   - else if ex_valid: ex_ready=1; the ex result is written with 0-cycle latency.
//   - else if FIFO non-empty: the head is popped and written.
//   - else: we3=0.
//   - ex_ready=1 whenever not starve (independent of ex_valid).
// - Writes to address 0 are accepted/popped normally but we3 stays 0.
// - Pointers wrap modulo DEPTH; count has ADDRW-independent width $clog2(DEPTH)+1.
// - Simultaneous push and pop: the count is unchanged; a push into an empty FIFO cannot pop the same cycle.
// - Pending flags:
//   - qN_pend=1 iff some valid FIFO entry has rd==qN and qN!=0.
//   - Flags are combinational from registered contents; the entry popped this cycle still counts as pending.
// - Reset mid-operation discards buffered responses; the upstream must reissue them.
// TESTING
// - rst=1 with ex_valid=1, rd=5 -> ex_ready=0, we3=0. Cycle after release: mem_ready=1, q*_pend=0.
// - ex_valid, rd=5, data=0xDEADBEEF, FIFO empty -> same cycle: we3=1, a3=5, wd3=0xDEADBEEF, port_a_busy=1.
// - Cycle N: ex rd=3 plus mem rd=7, data=0x11.
//   - N: we3 for rd 3.
//   - N+1 (ex idle): q1=7 gives q1_pend=1; we3, a3=7, wd3=0x11.
//   - N+2: q1_pend=0.
// - ex_valid held high; push 4 mem responses on cycles 0-3 -> mem_ready=0 from cycle 4 until the first pop.
// - One mem push at cycle 0 under continuous ex_valid, STARVE_LIMIT=8.
//   - Cycle 9: ex_ready=0, we3 writes the mem entry.
//   - Cycle 10: ex_ready=1, age=0.
// - ex rd=0 -> ex_ready=1, we3=0. A mem rd=0 entry is popped with we3=0 and count decremented.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the register file's single write port: in-order execute
// results versus buffered out-of-order memory responses, with an anti-starvation age.
module wb_arbiter #(
    parameter int DATAW        = 32,
    parameter int ADDRW        = 6,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [ADDRW-1:0] ex_rd,
    input  logic [DATAW-1:0] ex_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [ADDRW-1:0] mem_rd,
    input  logic [DATAW-1:0] mem_data,
    output logic             we3,
    output logic [ADDRW-1:0] a3,
    output logic [DATAW-1:0] wd3,
    output logic             port_a_busy,
    input  logic [ADDRW-1:0] q1,
    input  logic [ADDRW-1:0] q2,
    output logic             q1_pend,
    output logic             q2_pend
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(STARVE_LIMIT + 1);

    logic [ADDRW-1:0] rd_mem_q   [DEPTH];
    logic [ADDRW-1:0] rd_mem_d   [DEPTH];
    logic [DATAW-1:0] data_mem_q [DEPTH];
    logic [DATAW-1:0] data_mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    age_q, age_d;

    logic full_s, empty_s, starve_s, push_s, pop_s, ex_take_s;
    logic p1_s, p2_s;

    // Grant, FIFO bookkeeping, age counter and write-port outputs.
    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        valid_d    = valid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        age_d      = age_q;
        we3        = 1'b0;
        a3         = {ADDRW{1'b0}};
        wd3        = {DATAW{1'b0}};

        full_s    = (count_q == CW'(DEPTH));
        empty_s   = (count_q == {CW{1'b0}});
        starve_s  = (age_q >= AW'(STARVE_LIMIT));
        mem_ready = ~rst & ~full_s;
        ex_ready  = ~rst & ~starve_s;
        push_s    = mem_valid & mem_ready;
        ex_take_s = ex_valid & ex_ready;

        // Starvation always implies a non-empty FIFO, since age only grows while occupied.
        if (rst) begin
            pop_s = 1'b0;
        end else if (starve_s) begin
            pop_s = 1'b1;
        end else if (ex_valid) begin
            pop_s = 1'b0;
        end else begin
            pop_s = ~empty_s;
        end

        if (pop_s) begin
            we3 = (rd_mem_q[rd_ptr_q] != {ADDRW{1'b0}});
            a3  = rd_mem_q[rd_ptr_q];
            wd3 = data_mem_q[rd_ptr_q];
        end else if (ex_take_s) begin
            we3 = (ex_rd != {ADDRW{1'b0}});
            a3  = ex_rd;
            wd3 = ex_data;
        end else begin
            we3 = 1'b0;
        end

        if (push_s) begin
            rd_mem_d[wr_ptr_q]   = mem_rd;
            data_mem_d[wr_ptr_q] = mem_data;
            valid_d[wr_ptr_q]    = 1'b1;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop_s || empty_s) begin
            age_d = {AW{1'b0}};
        end else if (age_q < AW'(STARVE_LIMIT)) begin
            age_d = age_q + AW'(1);
        end else begin
            age_d = age_q;
        end
    end

    assign port_a_busy = we3;

    // Hazard flags look only at registered contents; the entry being popped still counts.
    always_comb begin
        p1_s = 1'b0;
        p2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (rd_mem_q[i] == q1)) begin
                p1_s = 1'b1;
            end else begin
                p1_s = p1_s;
            end
            if (valid_q[i] && (rd_mem_q[i] == q2)) begin
                p2_s = 1'b1;
            end else begin
                p2_s = p2_s;
            end
        end
        q1_pend = ~rst & p1_s & (q1 != {ADDRW{1'b0}});
        q2_pend = ~rst & p2_s & (q2 != {ADDRW{1'b0}});
    end

    // State registers with synchronous reset; buffered entries are discarded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= {DEPTH{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            age_q    <= {AW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= {ADDRW{1'b0}};
                data_mem_q[i] <= {DATAW{1'b0}};
            end
        end else begin
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            age_q      <= age_d;
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter plus hand sequences for the
// starvation and mid-operation reset corner cases.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [5:0]  ex_rd = 6'd0;
    logic [31:0] ex_data = 32'd0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [5:0]  mem_rd = 6'd0;
    logic [31:0] mem_data = 32'd0;
    logic        we3;
    logic [5:0]  a3;
    logic [31:0] wd3;
    logic        port_a_busy;
    logic [5:0]  q1 = 6'd0;
    logic [5:0]  q2 = 6'd0;
    logic        q1_pend;
    logic        q2_pend;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DATAW(32), .ADDRW(6), .DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .we3(we3), .a3(a3), .wd3(wd3), .port_a_busy(port_a_busy),
        .q1(q1), .q2(q2), .q1_pend(q1_pend), .q2_pend(q2_pend)
    );

    typedef struct {
        logic        rst;
        logic        exv;
        logic [5:0]  exrd;
        logic [31:0] exd;
        logic        mv;
        logic [5:0]  mrd;
        logic [31:0] md;
        logic [5:0]  q1;
        logic [5:0]  q2;
        logic        er;
        logic        mr;
        logic        we;
        logic [5:0]  a3;
        logic [31:0] wd;
        logic        p1;
        logic        p2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic exv, logic [5:0] exrd, logic [31:0] exd,
                                logic mv, logic [5:0] mrd, logic [31:0] md,
                                logic [5:0] qa, logic [5:0] qb,
                                logic er, logic mr, logic we, logic [5:0] ea3,
                                logic [31:0] ewd, logic p1, logic p2);
        vec_t v;
        v.rst = r; v.exv = exv; v.exrd = exrd; v.exd = exd;
        v.mv = mv; v.mrd = mrd; v.md = md; v.q1 = qa; v.q2 = qb;
        v.er = er; v.mr = mr; v.we = we; v.a3 = ea3; v.wd = ewd; v.p1 = p1; v.p2 = p2;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs away from the edge, then compare the settled outputs.
    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        rst = v.rst; ex_valid = v.exv; ex_rd = v.exrd; ex_data = v.exd;
        mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md; q1 = v.q1; q2 = v.q2;
        #1;
        check({tag, ".ex_ready"}, {31'd0, ex_ready}, {31'd0, v.er});
        check({tag, ".mem_ready"}, {31'd0, mem_ready}, {31'd0, v.mr});
        check({tag, ".we3"}, {31'd0, we3}, {31'd0, v.we});
        check({tag, ".port_a_busy"}, {31'd0, port_a_busy}, {31'd0, v.we});
        check({tag, ".q1_pend"}, {31'd0, q1_pend}, {31'd0, v.p1});
        check({tag, ".q2_pend"}, {31'd0, q2_pend}, {31'd0, v.p2});
        if (v.we || v.rst) begin
            check({tag, ".a3"}, {26'd0, a3}, {26'd0, v.a3});
            check({tag, ".wd3"}, wd3, v.wd);
        end
    endtask

    initial begin
        //            rst exv rd   exd           mv mrd  md        q1    q2     er mr we a3   wd            p1 p2
        tbl.push_back(mk(1, 1, 6'd5, 32'h0,        0, 6'd0, 32'h0,   6'd0, 6'd0,  0, 0, 0, 6'd0, 32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        0, 6'd0, 32'h0,   6'd0, 6'd0,  1, 1, 0, 6'd0, 32'h0,        0, 0));
        tbl.push_back(mk(0, 1, 6'd5, 32'hDEADBEEF, 0, 6'd0, 32'h0,   6'd0, 6'd0,  1, 1, 1, 6'd5, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 1, 6'd3, 32'h33,       1, 6'd7, 32'h11,  6'd7, 6'd0,  1, 1, 1, 6'd3, 32'h33,       0, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        0, 6'd0, 32'h0,   6'd7, 6'd0,  1, 1, 1, 6'd7, 32'h11,       1, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        0, 6'd0, 32'h0,   6'd7, 6'd0,  1, 1, 0, 6'd0, 32'h0,        0, 0));
        // fill to full under continuous execute traffic
        tbl.push_back(mk(0, 1, 6'd1, 32'hA0,       1, 6'd10, 32'h100, 6'd10, 6'd13, 1, 1, 1, 6'd1, 32'hA0,     0, 0));
        tbl.push_back(mk(0, 1, 6'd1, 32'hA1,       1, 6'd11, 32'h101, 6'd10, 6'd13, 1, 1, 1, 6'd1, 32'hA1,     1, 0));
        tbl.push_back(mk(0, 1, 6'd1, 32'hA2,       1, 6'd12, 32'h102, 6'd10, 6'd13, 1, 1, 1, 6'd1, 32'hA2,     1, 0));
        tbl.push_back(mk(0, 1, 6'd1, 32'hA3,       1, 6'd13, 32'h103, 6'd10, 6'd13, 1, 1, 1, 6'd1, 32'hA3,     1, 0));
        tbl.push_back(mk(0, 1, 6'd1, 32'hA4,       1, 6'd20, 32'h200, 6'd10, 6'd13, 1, 0, 1, 6'd1, 32'hA4,     1, 1));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        1, 6'd20, 32'h200, 6'd10, 6'd13, 1, 0, 1, 6'd10, 32'h100,   1, 1));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        0, 6'd0, 32'h0,   6'd10, 6'd13, 1, 1, 1, 6'd11, 32'h101,   0, 1));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        0, 6'd0, 32'h0,   6'd10, 6'd13, 1, 1, 1, 6'd12, 32'h102,   0, 1));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        0, 6'd0, 32'h0,   6'd10, 6'd13, 1, 1, 1, 6'd13, 32'h103,   0, 1));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        0, 6'd0, 32'h0,   6'd10, 6'd13, 1, 1, 0, 6'd0, 32'h0,      0, 0));
        // address-0 writes: accepted and popped but never written
        tbl.push_back(mk(0, 1, 6'd0, 32'h55,       1, 6'd0, 32'h66,  6'd0, 6'd0,  1, 1, 0, 6'd0, 32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        0, 6'd0, 32'h0,   6'd0, 6'd0,  1, 1, 0, 6'd0, 32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        1, 6'd9, 32'h99,  6'd9, 6'd0,  1, 1, 0, 6'd0, 32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        0, 6'd0, 32'h0,   6'd9, 6'd0,  1, 1, 1, 6'd9, 32'h99,       1, 0));
        tbl.push_back(mk(0, 0, 6'd0, 32'h0,        0, 6'd0, 32'h0,   6'd9, 6'd0,  1, 1, 0, 6'd0, 32'h0,        0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Starvation: one push at cycle 0, execute stream never idles.
        for (int c = 0; c <= 10; c++) begin
            vec_t v;
            if (c == 9)
                v = mk(0, 1, 6'd2, 32'hB0 + 32'(c), 0, 6'd0, 32'h0, 6'd4, 6'd0, 0, 1, 1, 6'd4, 32'h44, 1, 0);
            else if (c == 0)
                v = mk(0, 1, 6'd2, 32'hB0 + 32'(c), 1, 6'd4, 32'h44, 6'd4, 6'd0, 1, 1, 1, 6'd2, 32'hB0 + 32'(c), 0, 0);
            else if (c == 10)
                v = mk(0, 1, 6'd2, 32'hB0 + 32'(c), 0, 6'd0, 32'h0, 6'd4, 6'd0, 1, 1, 1, 6'd2, 32'hB0 + 32'(c), 0, 0);
            else
                v = mk(0, 1, 6'd2, 32'hB0 + 32'(c), 0, 6'd0, 32'h0, 6'd4, 6'd0, 1, 1, 1, 6'd2, 32'hB0 + 32'(c), 1, 0);
            apply(v, $sformatf("starve_c%0d", c));
        end

        // Reset mid-operation discards a buffered response.
        apply(mk(0, 1, 6'd2, 32'hC0, 1, 6'd6, 32'h66, 6'd6, 6'd0, 1, 1, 1, 6'd2, 32'hC0, 0, 0), "midrst_push");
        apply(mk(0, 1, 6'd2, 32'hC1, 0, 6'd0, 32'h0,  6'd6, 6'd0, 1, 1, 1, 6'd2, 32'hC1, 1, 0), "midrst_held");
        apply(mk(1, 1, 6'd2, 32'hC2, 1, 6'd8, 32'h88, 6'd6, 6'd0, 0, 0, 0, 6'd0, 32'h0,  0, 0), "midrst_rst");
        apply(mk(0, 0, 6'd0, 32'h0,  0, 6'd0, 32'h0,  6'd6, 6'd8, 1, 1, 0, 6'd0, 32'h0,  0, 0), "midrst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
